button_debouncer: RTL and testbench
===================================

# button_debouncer

Debounces a raw mechanical push-button, sampling it on strobes derived from the 100 µs debounce square wave of the slow clock divider. Emits a clean level plus single-cycle press, release and long-press pulses. The press pulse is the advance strobe for the state-sequencing stage downstream, which must step exactly once per physical press.

## Interface

**Parameters**
- `STABLE_TICKS`, default 4: consecutive agreeing samples required to accept a level change. Legal range ≥ 1.
- `LONG_TICKS`, default 8192: held samples before the long press fires. At 102.4 µs per sample this is ≈ 839 ms. Legal range ≥ 1.
- `ACTIVE_LOW`, default 1: when 1, `button_in` = 0 means pressed.

**Ports**
- `clk` input 1: system clock (2.5 MHz in the timing build).
- `rst_n` input 1: asynchronous, active-low reset.
- `tick_in` input 1: debounce square wave from the clock divider. Synchronous to `clk`. Only its rising edges are used.
- `button_in` input 1: raw button pin. Asynchronous to `clk`.
- `btn_level` output 1: debounced level, 1 = pressed.
- `press_pulse` output 1: one-cycle strobe on an accepted press.
- `release_pulse` output 1: one-cycle strobe on an accepted release.
- `long_press_pulse` output 1: one-cycle strobe after `LONG_TICKS` held samples. Fires once per press.

## Operation

- **Synchronisation:** `button_in` passes through a 2-flop synchroniser. The result is XORed with `ACTIVE_LOW` to give `raw_pressed`.
- **Sample strobe:** `tick_d` is a register of `tick_in`. The strobe is `tick_en = tick_in & ~tick_d`. Only `tick_en` cycles sample `raw_pressed`. All other cycles hold state.
- **Stability counter:** `stab_cnt`, width `$clog2(STABLE_TICKS+1)`.
- **Hold counter:** `hold_cnt`, width `$clog2(LONG_TICKS+1)`. Saturates at `LONG_TICKS`.

**States**
- **IDLE**
  - Sample pressed: go to ARMING with `stab_cnt` = 1.
  - If `STABLE_TICKS` = 1, go straight to HELD and fire the press.
- **ARMING**
  - Sample pressed: increment `stab_cnt`. On reaching `STABLE_TICKS`, go to HELD, assert `press_pulse`, set `hold_cnt` = 0.
  - Sample released: return to IDLE and clear `stab_cnt`. No pulse.
- **HELD**
  - Sample pressed: increment `hold_cnt`. On the transition to exactly `LONG_TICKS`, assert `long_press_pulse`.
  - Sample released: go to RELEASING with `stab_cnt` = 1.
  - If `STABLE_TICKS` = 1, go straight to IDLE and fire the release.
- **RELEASING**
  - Sample released: increment `stab_cnt`. On reaching `STABLE_TICKS`, go to IDLE and assert `release_pulse`.
  - Sample pressed: return to HELD. `hold_cnt` keeps its value. No pulse.

**Output rules**
- `btn_level` is 1 in HELD and RELEASING, and 0 otherwise.
- At most one pulse output is high in any cycle.
- `long_press_pulse` never fires outside HELD.
- A bounce during ARMING or RELEASING restarts qualification. It never produces a pulse.

## Timing

- **Reset:** all outputs 0. State = IDLE, counters 0, `tick_d` = 0, synchroniser flops = not-pressed level.
- **Mid-operation reset:** takes effect immediately. Outputs drop the same instant. No pulses are emitted on reset deassertion.
- **Pulse timing:** all outputs are registered. A pulse is high for exactly the one `clk` cycle after the `tick_en` cycle that qualified it.
- **Synchroniser latency:** `raw_pressed` reflects a pin change 2 cycles later. Samples only use the synchronised value.
- **Press latency:** between (`STABLE_TICKS`−1) and `STABLE_TICKS` tick periods, plus 3 cycles, from a clean pin edge.
- **Clean long press:** `long_press_pulse` comes exactly `LONG_TICKS` tick periods after `press_pulse`.
- **Tick held high:** produces one strobe only.
- **Tick glitch:** a glitch of one `clk` cycle still counts as one strobe. The divider is glitch-free by construction.
- **Counter wrap:** none. `hold_cnt` saturates and is not cleared until exit to IDLE.

## Structure

- **Shared package `pop_timing_pkg`**
  - Typedef `debounce_state_t` with encodings IDLE = 2'd0, ARMING = 2'd1, HELD = 2'd2, RELEASING = 2'd3.
  - Default constants `DEBOUNCE_STABLE_TICKS` = 4 and `LONG_PRESS_TICKS` = 8192, so all instances agree.
- **Sub-module `sync_2ff`**
  - Generic 2-flop synchroniser, with a reset-value parameter.
  - Instantiated once here and reused for other asynchronous pins.

## Test plan

Common bench setup: `STABLE_TICKS` = 4, `LONG_TICKS` = 16, `ACTIVE_LOW` = 1. `tick_in` is a square wave with period 8 `clk` cycles.

1. **Clean press:** drive `button_in` 1→0 and hold for 40 ticks → exactly one `press_pulse` and `btn_level` = 1 within 4 ticks + 3 cycles. One `long_press_pulse` 16 ticks after the press.
2. **Bouncy press:** toggle the pin every tick for 6 ticks, then hold at 0 → no pulses during the bounce. One `press_pulse` 4 ticks after settling.
3. **Short glitch:** pin low for 3 ticks, then high → no pulses, `btn_level` stays 0, state returns to IDLE.
4. **Release bounce:** from HELD, pin high 2 ticks, low 1 tick, high 5 ticks → single `release_pulse` only after 4 consecutive high samples. `hold_cnt` is preserved through the bounce.
5. **Reset mid-operation:** assert `rst_n` = 0 in HELD with `hold_cnt` = 10 → all outputs 0 immediately. After release with the pin still low, a fresh `press_pulse` comes 4 ticks later.
6. **Parameter edge:** `STABLE_TICKS` = 1, `LONG_TICKS` = 1 → press on the first pressed sample. Long press on the next tick. Release on the first released sample.

Source files
------------

// File: rtl/pop_timing_pkg.sv
// Shared timing definitions for the push-button front end.
// Holds the debouncer state encoding and the default qualification
// constants, so every instance agrees on them.
package pop_timing_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } debounce_state_t;

  localparam int unsigned DEBOUNCE_STABLE_TICKS = 4;
  localparam int unsigned LONG_PRESS_TICKS      = 8192;

endpackage

// File: rtl/button_debouncer_if.sv
// Signal bundle between the debouncer and its surroundings.
//   tick_in          : debounce square wave (rising edges sample)
//   button_in        : raw button pin, asynchronous
//   btn_level        : debounced level, 1 = pressed
//   press_pulse      : one-cycle strobe on accepted press
//   release_pulse    : one-cycle strobe on accepted release
//   long_press_pulse : one-cycle strobe after the long-press hold time
// master drives tick/pin and consumes the results; slave is the debouncer.
interface button_debouncer_if;
  logic tick_in;
  logic button_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_press_pulse;

  modport master (
    output tick_in,
    output button_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_press_pulse
  );

  modport slave (
    input  tick_in,
    input  button_in,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_press_pulse
  );
endinterface

// File: rtl/button_debouncer_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous single-bit pins.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_d        : asynchronous input
//   o_q        : synchronised output (2 cycles latency)
// RESET_VAL sets the idle level both flops hold during reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer sampled on rising edges of the debounce tick.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : button_debouncer_if slave (tick/pin in; level and
//                press/release/long-press strobes out, all registered)
// A level change is accepted after STABLE_TICKS agreeing samples; a
// long press fires once after LONG_TICKS held samples.
module button_debouncer
  import pop_timing_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEBOUNCE_STABLE_TICKS,
  parameter int unsigned LONG_TICKS   = LONG_PRESS_TICKS,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  button_debouncer_if.slave bus
);

  localparam int unsigned SW = $clog2(STABLE_TICKS + 1);
  localparam int unsigned HW = $clog2(LONG_TICKS + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_TICKS);
  localparam logic [SW-1:0] STAB_ONE = SW'(1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  logic            w_sync_pin;
  logic            w_raw_pressed;
  logic            w_tick_en;
  logic [SW-1:0]   w_stab_inc;
  logic [HW-1:0]   w_hold_inc;

  debounce_state_t r_state,  w_state_nxt;
  logic [SW-1:0]   r_stab_cnt, w_stab_nxt;
  logic [HW-1:0]   r_hold_cnt, w_hold_nxt;
  logic            r_tick_d;
  logic            r_level,   w_level_nxt;
  logic            r_press,   w_press_nxt;
  logic            r_release, w_release_nxt;
  logic            r_long,    w_long_nxt;

  // Synchroniser idles at the not-pressed pin level.
  sync_2ff #(.RESET_VAL(ACTIVE_LOW)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.button_in),
    .o_q   (w_sync_pin)
  );

  assign w_raw_pressed = w_sync_pin ^ ACTIVE_LOW;
  assign w_tick_en     = bus.tick_in & ~r_tick_d;
  assign w_stab_inc    = r_stab_cnt + STAB_ONE;
  assign w_hold_inc    = r_hold_cnt + HOLD_ONE;

  always_comb begin
    w_state_nxt   = r_state;
    w_stab_nxt    = r_stab_cnt;
    w_hold_nxt    = r_hold_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
    if (w_tick_en) begin
      unique case (r_state)
        IDLE: begin
          if (w_raw_pressed) begin
            if (STABLE_TICKS == 1) begin
              w_state_nxt = HELD;
              w_press_nxt = 1'b1;
              w_hold_nxt  = '0;
              w_stab_nxt  = '0;
            end else begin
              w_state_nxt = ARMING;
              w_stab_nxt  = STAB_ONE;
            end
          end
        end
        ARMING: begin
          if (w_raw_pressed) begin
            if (w_stab_inc == STAB_MAX) begin
              w_state_nxt = HELD;
              w_press_nxt = 1'b1;
              w_hold_nxt  = '0;
              w_stab_nxt  = '0;
            end else begin
              w_stab_nxt  = w_stab_inc;
            end
          end else begin
            w_state_nxt = IDLE;
            w_stab_nxt  = '0;
          end
        end
        HELD: begin
          if (w_raw_pressed) begin
            // Saturating count; the strobe fires only on reaching the limit.
            if (r_hold_cnt != HOLD_MAX) begin
              w_hold_nxt = w_hold_inc;
              w_long_nxt = (w_hold_inc == HOLD_MAX);
            end
          end else if (STABLE_TICKS == 1) begin
            w_state_nxt   = IDLE;
            w_release_nxt = 1'b1;
            w_hold_nxt    = '0;
          end else begin
            w_state_nxt = RELEASING;
            w_stab_nxt  = STAB_ONE;
          end
        end
        RELEASING: begin
          if (!w_raw_pressed) begin
            if (w_stab_inc == STAB_MAX) begin
              w_state_nxt   = IDLE;
              w_release_nxt = 1'b1;
              w_stab_nxt    = '0;
              w_hold_nxt    = '0;
            end else begin
              w_stab_nxt    = w_stab_inc;
            end
          end else begin
            // Bounce back to HELD keeps the accumulated hold time.
            w_state_nxt = HELD;
            w_stab_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_stab_nxt  = '0;
          w_hold_nxt  = '0;
        end
      endcase
    end
    w_level_nxt = (w_state_nxt == HELD) || (w_state_nxt == RELEASING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_stab_cnt <= '0;
      r_hold_cnt <= '0;
      r_tick_d   <= 1'b0;
      r_level    <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_long     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_stab_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_tick_d   <= bus.tick_in;
      r_level    <= w_level_nxt;
      r_press    <= w_press_nxt;
      r_release  <= w_release_nxt;
      r_long     <= w_long_nxt;
    end
  end

  assign bus.btn_level        = r_level;
  assign bus.press_pulse      = r_press;
  assign bus.release_pulse    = r_release;
  assign bus.long_press_pulse = r_long;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: one instance with STABLE_TICKS=4,
// LONG_TICKS=16 and one with both set to 1, sharing clock, reset and an
// 8-cycle tick. Inputs change on the falling clock edge; outputs are
// sampled there too, and pulse counts/cycle stamps are compared against
// hand-derived values.
module tb_button_debouncer;
  import pop_timing_pkg::*;

  logic clk;
  logic rst_n;

  button_debouncer_if bus4 ();
  button_debouncer_if bus1 ();

  button_debouncer #(
    .STABLE_TICKS (4),
    .LONG_TICKS   (16),
    .ACTIVE_LOW   (1'b1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  button_debouncer #(
    .STABLE_TICKS (1),
    .LONG_TICKS   (1),
    .ACTIVE_LOW   (1'b1)
  ) u_dut_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int phase    = 7;
  int multi_n  = 0;
  int press4_n, release4_n, long4_n, press4_cyc, release4_cyc, long4_cyc;
  int press1_n, release1_n, long1_n, press1_cyc, release1_cyc, long1_cyc;
  int s, t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic clr_counts();
    press4_n = 0; release4_n = 0; long4_n = 0;
    press1_n = 0; release1_n = 0; long1_n = 0;
    press4_cyc = -1; release4_cyc = -1; long4_cyc = -1;
    press1_cyc = -1; release1_cyc = -1; long1_cyc = -1;
  endtask

  // One clk cycle: sample outputs at the falling edge, then advance the tick.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus4.press_pulse)      begin press4_n++;   press4_cyc   = cyc; end
    if (bus4.release_pulse)    begin release4_n++; release4_cyc = cyc; end
    if (bus4.long_press_pulse) begin long4_n++;    long4_cyc    = cyc; end
    if (bus1.press_pulse)      begin press1_n++;   press1_cyc   = cyc; end
    if (bus1.release_pulse)    begin release1_n++; release1_cyc = cyc; end
    if (bus1.long_press_pulse) begin long1_n++;    long1_cyc    = cyc; end
    if (int'(bus4.press_pulse) + int'(bus4.release_pulse) + int'(bus4.long_press_pulse) > 1)
      multi_n++;
    if (int'(bus1.press_pulse) + int'(bus1.release_pulse) + int'(bus1.long_press_pulse) > 1)
      multi_n++;
    phase = (phase + 1) % 8;
    bus4.tick_in = (phase < 4);
    bus1.tick_in = (phase < 4);
  endtask

  // Advance until n tick rising edges have been driven.
  task automatic ticks(input int n);
    repeat (n) begin
      do step(); while (phase != 0);
    end
  endtask

  initial begin
    rst_n          = 1'b1;
    bus4.tick_in   = 1'b0;
    bus1.tick_in   = 1'b0;
    bus4.button_in = 1'b1;
    bus1.button_in = 1'b1;
    clr_counts();
    #2 rst_n = 1'b0;
    #1;
    check("rst_level",   bus4.btn_level, 0);
    check("rst_press",   bus4.press_pulse, 0);
    check("rst_release", bus4.release_pulse, 0);
    check("rst_long",    bus4.long_press_pulse, 0);
    check("rst_state",   32'(u_dut.r_state), 32'(IDLE));
    repeat (3) step();
    rst_n = 1'b1;
    ticks(2);

    // Clean press, long press, clean release
    clr_counts();
    ticks(1); s = cyc; bus4.button_in = 1'b0;
    ticks(40);
    check("t1_press_n",   press4_n, 1);
    check("t1_press_lat", press4_cyc - s, 33);
    check("t1_long_n",    long4_n, 1);
    check("t1_long_gap",  long4_cyc - press4_cyc, 128);
    check("t1_level",     bus4.btn_level, 1);
    check("t1_hold_sat",  u_dut.r_hold_cnt, 16);
    t = cyc; bus4.button_in = 1'b1;
    ticks(6);
    check("t1_rel_n",     release4_n, 1);
    check("t1_rel_lat",   release4_cyc - t, 33);
    check("t1_level_off", bus4.btn_level, 0);

    // Bouncy press
    clr_counts();
    ticks(1);
    for (int i = 0; i < 6; i++) begin
      bus4.button_in = i[0];
      ticks(1);
    end
    check("t2_bounce_press", press4_n, 0);
    check("t2_bounce_rel",   release4_n, 0);
    s = cyc; bus4.button_in = 1'b0;
    ticks(6);
    check("t2_press_n",   press4_n, 1);
    check("t2_press_lat", press4_cyc - s, 33);
    bus4.button_in = 1'b1;
    ticks(6);
    check("t2_rel_n",     release4_n, 1);

    // Short glitch
    clr_counts();
    ticks(1); bus4.button_in = 1'b0;
    ticks(3);
    check("t3_arming",    32'(u_dut.r_state), 32'(ARMING));
    check("t3_stab",      u_dut.r_stab_cnt, 2);
    bus4.button_in = 1'b1;
    ticks(4);
    check("t3_pulses",    press4_n + release4_n + long4_n, 0);
    check("t3_level",     bus4.btn_level, 0);
    check("t3_idle",      32'(u_dut.r_state), 32'(IDLE));

    // Release bounce
    clr_counts();
    ticks(1); bus4.button_in = 1'b0;
    ticks(6); bus4.button_in = 1'b1;
    ticks(2); bus4.button_in = 1'b0;
    ticks(1); t = cyc; bus4.button_in = 1'b1;
    step();
    check("t4_back_held", 32'(u_dut.r_state), 32'(HELD));
    check("t4_hold_keep", u_dut.r_hold_cnt, 2);
    check("t4_level",     bus4.btn_level, 1);
    ticks(5);
    check("t4_press_n",   press4_n, 1);
    check("t4_rel_n",     release4_n, 1);
    check("t4_rel_lat",   release4_cyc - t, 33);
    check("t4_long_n",    long4_n, 0);
    check("t4_hold_clr",  u_dut.r_hold_cnt, 0);

    // Reset in HELD
    clr_counts();
    ticks(1); bus4.button_in = 1'b0;
    ticks(14);
    step();
    check("t5_hold10",    u_dut.r_hold_cnt, 10);
    check("t5_level_pre", bus4.btn_level, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_level", bus4.btn_level, 0);
    check("t5_rst_hold",  u_dut.r_hold_cnt, 0);
    clr_counts();
    ticks(1);
    rst_n = 1'b1; s = cyc;
    ticks(5);
    check("t5_press_n",   press4_n, 1);
    check("t5_press_lat", press4_cyc - s, 33);
    check("t5_other",     release4_n + long4_n, 0);
    bus4.button_in = 1'b1;
    ticks(6);
    check("t5_rel_n",     release4_n, 1);

    // STABLE_TICKS = LONG_TICKS = 1
    check("t6_quiet",     press1_n + release1_n + long1_n, 0);
    clr_counts();
    ticks(1); s = cyc; bus1.button_in = 1'b0;
    ticks(3); t = cyc; bus1.button_in = 1'b1;
    ticks(3);
    check("t6_press_n",   press1_n, 1);
    check("t6_press_lat", press1_cyc - s, 9);
    check("t6_long_n",    long1_n, 1);
    check("t6_long_gap",  long1_cyc - press1_cyc, 8);
    check("t6_rel_n",     release1_n, 1);
    check("t6_rel_lat",   release1_cyc - t, 9);
    check("t6_level",     bus1.btn_level, 0);

    check("one_pulse_per_cycle", multi_n, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
